port_0: RTL and testbench

//   General-purpose 16-bit I/O port register on the CPU's shared tri-state data bus.
//   - Write: the CPU stores a word from data_bus into the port latch.
//   - data_out continuously drives the latched word to the external pins.
//   - Read: the port drives its latched word back onto data_bus.
//   - Sits alongside the other bus-attached registers, selected by read/write strobes.

---
 rtl/port_0_if.sv | 39 +++
 rtl/port_0.sv | 51 +++++
 tb/tb_port_0.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/port_0_if.sv
// ---------------------------------------------------------------------------
// port_0_if
//   Bus bundle between the CPU side and the 16-bit I/O port register.
//   Groups the read/write strobes, the shared tri-state data bus and the
//   external pin outputs so that they travel together.
//
//   Signals
//     read      1      1 = port drives its latch onto data_bus
//     write     1      1 = port captures data_bus at the next rising clk edge
//     data_bus  WIDTH  shared tri-state CPU data bus (resolved net)
//     data_out  WIDTH  external port pins, always equal to the latch
//
//   Modports
//     master    CPU / bench side: drives the strobes, observes the pins
//     slave     port side: receives the strobes, drives the pins
// ---------------------------------------------------------------------------
interface port_0_if #(
    parameter int WIDTH = 16
);
    logic             read;
    logic             write;
    // Several agents drive the bus, so it is a resolved net rather than a variable.
    wire  [WIDTH-1:0] data_bus;
    logic [WIDTH-1:0] data_out;

    modport master (
        output read,
        output write,
        inout  data_bus,
        input  data_out
    );

    modport slave (
        input  read,
        input  write,
        inout  data_bus,
        output data_out
    );
endinterface

// File: rtl/port_0.sv
// ---------------------------------------------------------------------------
// port_0
//   General-purpose I/O port register on the CPU's shared tri-state data bus.
//   A write strobe stores the bus word into the port latch. The latch is
//   shown continuously on the external pins. A read strobe puts the latch
//   back onto the bus.
//
//   Parameters
//     WIDTH    data bus and latch width in bits
//     RST_VAL  value loaded into the latch by reset
//
//   Ports
//     clk      in     system clock, all state changes on the rising edge
//     reset    in     synchronous, active-high reset
//     bus      slave  read/write strobes, data_bus (inout), data_out (out)
// ---------------------------------------------------------------------------
module port_0 #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic     clk,
    input  logic     reset,
    port_0_if.slave  bus
);

    logic [WIDTH-1:0] r_q;
    logic             w_drive;

    // The port latch. Reset takes priority over a pending write. With no
    // strobe the word is held indefinitely. A write captures whatever is on
    // the bus, with no masking. If nobody drives the bus, the latch takes
    // the floating value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else if (bus.write) begin
            r_q <= bus.data_bus;
        end
    end

    // The port drives the bus only for a pure read. If a write is also
    // present, another agent owns the bus, so the port stays off it. Reset
    // releases the bus at once, without waiting for a clock edge.
    assign w_drive = bus.read & ~bus.write & ~reset;

    assign bus.data_bus = w_drive ? r_q : {WIDTH{1'bz}};

    // The pins follow the latch directly and are never tri-stated.
    assign bus.data_out = r_q;

endmodule

// File: tb/tb_port_0.sv
// ---------------------------------------------------------------------------
// tb_port_0
//   Bench for the 16-bit bus-attached I/O port register port_0.
// ---------------------------------------------------------------------------
module tb_port_0;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] RST_VAL = 16'h0000;

    logic             clk;
    logic             reset;
    logic             tbDrive;
    logic [WIDTH-1:0] tbValue;

    // Expected latch contents, kept as a plain word.
    logic [WIDTH-1:0] modelQ;

    int testCount;
    int failCount;

    port_0_if #(.WIDTH(WIDTH)) busIf ();

    port_0 #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf.slave)
    );

    // The bench acts as the external bus master.
    // It puts a word on the shared bus only while tbDrive is set.
    assign busIf.data_bus = tbDrive ? tbValue : {WIDTH{1'bz}};

    // 20 ns clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Compare an observed word against the expected word.
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // The bus counts as released when no driver is present.
    // A four-state simulator shows Z here. A two-state simulator resolves an
    // undriven net to zero. Callers use this check only while the latch holds
    // a nonzero word, so that a port which wrongly drives the bus is visible.
    task automatic checkReleased(input string tag);
        logic [WIDTH-1:0] observed;
        observed = busIf.data_bus;
        testCount++;
        assert ($isunknown(observed) || observed === {WIDTH{1'b0}})
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=released", tag, observed);
        end
    endtask

    // Run one clock cycle.
    // The inputs are applied after the falling edge. The combinational bus is
    // checked mid-cycle. The model is then advanced and the pins are checked
    // just after the rising edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic rd,
                                 input logic wr, input logic drv,
                                 input logic [WIDTH-1:0] val, input logic checkBus);
        @(negedge clk);
        reset         = rst;
        busIf.read    = rd;
        busIf.write   = wr;
        tbDrive       = drv;
        tbValue       = val;
        #2;
        if (checkBus) begin
            if (drv)
                checkOutput({tag, "_bus_ext"}, busIf.data_bus, val);
            else if (rd && !wr && !rst)
                checkOutput({tag, "_bus_read"}, busIf.data_bus, modelQ);
            else if (modelQ != '0)
                checkReleased({tag, "_bus_rel"});
        end
        @(posedge clk);
        if (rst)
            modelQ = RST_VAL;
        else if (wr)
            modelQ = drv ? val : 'x;
        #1;
        checkOutput({tag, "_out"}, busIf.data_out, modelQ);
    endtask

    // Directed scenarios first, then a randomized run against the model.
    initial begin
        logic             rRst;
        logic             rRd;
        logic             rWr;
        logic             rDrv;
        logic [WIDTH-1:0] rVal;

        testCount   = 0;
        failCount   = 0;
        reset       = 1'b0;
        busIf.read  = 1'b0;
        busIf.write = 1'b0;
        tbDrive     = 1'b0;
        tbValue     = '0;
        modelQ      = 'x;

        // Reset, with both strobes idle.
        applyStimulus("reset", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Read the reset value back with no external driver.
        applyStimulus("read0", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Write 0001 from the external master.
        applyStimulus("wr0001", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1);

        // Read it back, then drop read and check that the bus is released.
        applyStimulus("read0001", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        applyStimulus("idle0001", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Read and write together: the write wins and the port stays off the bus.
        applyStimulus("rdwrA5A5", 1'b0, 1'b1, 1'b1, 1'b1, 16'hA5A5, 1'b1);

        // Hold across several idle cycles.
        for (int i = 0; i < 3; i++)
            applyStimulus("holdA5A5", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Reset asserted mid-read releases the bus combinationally.
        // A write of FFFF in the same cycle is overridden by the reset.
        @(negedge clk);
        busIf.read = 1'b1;
        #2;
        checkOutput("preRst_bus_read", busIf.data_bus, 16'hA5A5);
        reset = 1'b1;
        #2;
        checkReleased("rstMid_bus_rel");
        busIf.write = 1'b1;
        tbDrive     = 1'b1;
        tbValue     = 16'hFFFF;
        @(posedge clk);
        modelQ = RST_VAL;
        #1;
        checkOutput("rstOverWr_out", busIf.data_out, 16'h0000);

        // Randomized cycles, checked against the model.
        // The bench drives the bus whenever it writes, and sometimes during
        // idle cycles. It never drives while the port performs a pure read.
        for (int i = 0; i < 200; i++) begin
            rRst = ($urandom_range(0, 9) == 0);
            rRd  = $urandom_range(0, 1) == 1;
            rWr  = $urandom_range(0, 1) == 1;
            rVal = WIDTH'($urandom);
            if (rWr)
                rDrv = 1'b1;
            else if (rRd && !rRst)
                rDrv = 1'b0;
            else
                rDrv = $urandom_range(0, 1) == 1;
            applyStimulus("rand", rRst, rRd, rWr, rDrv, rVal, 1'b1);
        end

        @(negedge clk);
        reset       = 1'b0;
        busIf.read  = 1'b0;
        busIf.write = 1'b0;
        tbDrive     = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
